tx_frame_padder: RTL
====================

# tx_frame_padder

- Sits in the 10G transmit path directly upstream of the TX store-and-forward interface and drives that stage's 64-bit AXI4-Stream input.
- Pads every outgoing Ethernet frame shorter than 60 bytes (minimum frame, excluding FCS) to exactly 60 bytes with zero bytes. The XGMAC appends the FCS.
- Frames of 60 bytes or more pass through unmodified.
- Output is fully registered. One beat per cycle is sustained on pass-through traffic.

## Interface
Parameters:
- none.

Ports:
- user_clk  input  1  single clock for all logic.
- aresetn  input  1  reset, asynchronous assert, active-low.
- s_axis_tdata  input  64  frame data from the protocol stack; byte 0 is [7:0].
- s_axis_tkeep  input  8  byte enables, contiguous from bit 0.
- s_axis_tvalid  input  1  upstream beat valid.
- s_axis_tlast  input  1  last beat of frame.
- s_axis_tready  output  1  block accepts beat.
- m_axis_tdata  output  64  padded data toward the TX interface.
- m_axis_tkeep  output  8  byte enables out.
- m_axis_tvalid  output  1  output beat valid.
- m_axis_tlast  output  1  output last beat.
- m_axis_tready  input  1  downstream ready.
- padded_frame_cnt  output  32  padded-frame counter; present only with ETH_PAD_STATS_EN.

## Operation
- Beat index counter: 0..8, saturating at 8.
  - Increments on every beat loaded into the output register.
  - Resets to 0 after a tlast beat is loaded.
- Minimum frame layout is 8 beats: beats 0–6 carry tkeep 0xFF; beat 7 carries tkeep 0x0F.
- State PASS, input beat accepted with index i:
  - Not last: forward unchanged.
  - Last and i>=8: forward unchanged.
  - Last and i==7 with tkeep 0x0F or larger: forward unchanged.
  - Last and i==7 with tkeep 0x01, 0x03 or 0x07: output tkeep=0x0F, tlast=1, bytes not enabled on input zeroed. Counts as padded. Stay in PASS.
  - Last and i<7: output tkeep=0xFF, tlast=0, bytes not enabled on input zeroed. Go to PAD. Counts as padded.
- State PAD: emits zero-data beats with indices i+1..7.
  - Beats below index 7: tkeep 0xFF, tlast 0.
  - Beat 7: tkeep 0x0F, tlast 1.
  - Return to PASS when beat 7 is loaded into the output register.
- Upstream is never accepted while in PAD.
- Input tkeep is contiguous from bit 0; any tkeep on a last beat is accepted. A last beat with tkeep 0x00 is treated as zero valid bytes.
- Reset mid-frame discards the partial frame.
  - After reset, the first accepted beat is beat 0 of a new frame.
  - No padding is emitted for the discarded frame.

## Timing
- Reset values:
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0.
  - s_axis_tready=0 while aresetn low.
  - State PASS, counter 0, padded_frame_cnt=0.
- Output register loads when (!m_axis_tvalid | m_axis_tready).
- s_axis_tready = (!m_axis_tvalid | m_axis_tready) & (state==PASS). It is combinational from m_axis_tready and registered state.
- Latency: 1 cycle from input acceptance to m_axis_tvalid.
- Output holds tdata/tkeep/tlast/tvalid stable while tvalid=1 and tready=0.
- Throughput:
  - 1 beat/cycle in PASS.
  - Padded frame of k input beats (k<=7): exactly 8 output beats; upstream stalled 8−k cycles with m_axis_tready held high.
- A new frame's beat 0 is accepted in the cycle after the final pad beat is loaded, provided the output register can load.

## Configuration
- ETH_PAD_STATS_EN defined:
  - padded_frame_cnt exists.
  - Increments by 1 in the cycle the input last beat of a padded frame is accepted.
  - Wraps 0xFFFFFFFF→0.
  - Cleared only by reset.
- Not defined: port and counter logic absent; datapath identical.

## Test plan
- 1-beat frame, tkeep 0x3F, data 0x0000AABBCCDDEEFF, ready=1 → 8 output beats. Beat 0 = 0x0000AABBCCDDEEFF with tkeep 0xFF; beats 1–6 zero with 0xFF; beat 7 zero with tkeep 0x0F and tlast; s_axis_tready low 7 cycles; counter=1.
- 8-beat frame, last tkeep 0x03 → beat 7 tkeep 0x0F, bytes 2–3 zero, no stall, counter +1.
- 8-beat frame, last tkeep 0x0F, then 10-beat frame → both pass unchanged, back-to-back with no idle cycle, counter unchanged.
- 3-beat frame with m_axis_tready toggling 1,0,0,1 pattern → output beats held stable while stalled; 8 beats total; correct data order; tlast only on beat 7.
- aresetn low during PAD at beat 4, then 1-beat frame → no stale pad beats; new frame padded from beat 0; all outputs 0 during reset.
- Two padded frames separated by zero idle cycles → second frame's beat 0 accepted the cycle after the first frame's beat 7 loads; counter=2.

Source files
------------

// File: rtl/tx_frame_padder_if.sv
// 64-bit AXI4-Stream bundle shared by the padder's input and output ports.
// master drives data/valid/last, slave drives ready.
interface tx_frame_padder_if;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (
    output tdata, tkeep, tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tvalid, tlast,
    output tready
  );
endinterface

// File: rtl/tx_frame_padder.sv
// Pads short Ethernet frames to 60 bytes ahead of the TX store-and-forward.
// Optional padded-frame counter enabled with `define ETH_PAD_STATS_EN.
module tx_frame_padder (
  input  logic                user_clk,
  input  logic                aresetn,
  tx_frame_padder_if.slave    s_axis,
  tx_frame_padder_if.master   m_axis
`ifdef ETH_PAD_STATS_EN
  ,
  output logic [31:0]         padded_frame_cnt
`endif
);

  localparam logic [0:0] PASS = 1'b0;
  localparam logic [0:0] PAD  = 1'b1;

  logic [0:0]  state;
  logic [3:0]  idx;
  logic [63:0] q_data;
  logic [7:0]  q_keep;
  logic        q_last;
  logic        q_valid;

  logic        load;
  logic        accept;
  logic        short_last;
  logic        to_pad;
  logic        pad_done;
  logic [3:0]  idx_inc;
  logic [63:0] masked;

  assign m_axis.tdata  = q_data;
  assign m_axis.tkeep  = q_keep;
  assign m_axis.tlast  = q_last;
  assign m_axis.tvalid = q_valid;

  assign load = !q_valid | m_axis.tready;

  assign s_axis.tready = load & (state == PASS) & aresetn;

  assign accept = s_axis.tvalid & s_axis.tready;

  // A last beat is short if it ends before byte 60 of the frame
  assign to_pad = s_axis.tlast & (idx < 4'd7);
  assign short_last = s_axis.tlast &
    ((idx < 4'd7) | ((idx == 4'd7) & !s_axis.tkeep[3]));

  assign pad_done = (state == PAD) & (idx == 4'd7);
  assign idx_inc  = (idx == 4'd8) ? 4'd8 : idx + 4'd1;

  always_comb begin
    masked = '0;
    for (int b = 0; b < 8; b++) begin
      if (s_axis.tkeep[b]) begin
        masked[8*b +: 8] = s_axis.tdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge user_clk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= PASS;
      idx     <= '0;
      q_data  <= '0;
      q_keep  <= '0;
      q_last  <= 1'b0;
      q_valid <= 1'b0;
    end else if (load) begin
      unique case (1'b1)
        state == PAD: begin
          q_valid <= 1'b1;
          q_data  <= '0;
          q_keep  <= pad_done ? 8'h0F : 8'hFF;
          q_last  <= pad_done;
          idx     <= pad_done ? 4'd0 : idx_inc;
          state   <= pad_done ? PASS : PAD;
        end
        accept: begin
          q_valid <= 1'b1;
          if (short_last) begin
            q_data <= masked;
            q_keep <= to_pad ? 8'hFF : 8'h0F;
            q_last <= !to_pad;
            state  <= to_pad ? PAD : PASS;
          end else begin
            q_data <= s_axis.tdata;
            q_keep <= s_axis.tkeep;
            q_last <= s_axis.tlast;
          end
          idx <= (s_axis.tlast & !to_pad) ? 4'd0 : idx_inc;
        end
        default: begin
          q_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ETH_PAD_STATS_EN
  always_ff @(posedge user_clk or negedge aresetn) begin
    if (!aresetn) begin
      padded_frame_cnt <= '0;
    end else if (accept & short_last) begin
      padded_frame_cnt <= padded_frame_cnt + 32'd1;
    end
  end
`endif

endmodule
